// File: rtl/btn_debounce.sv
// Two-channel push-button debouncer for the paddle controls.
// Each channel has a 2-flop synchronizer, a four-state debounce FSM and an
// auto-repeat counter. Both channels feed a mutually exclusive move output.
module btn_debounce #(
    parameter int unsigned DB_TICKS      = 1000000,
    parameter int unsigned REPEAT_DELAY  = 30000000,
    parameter int unsigned REPEAT_PERIOD = 10000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] btn_raw,
    output logic [1:0] btn_db,
    output logic [1:0] btn_tick,
    output logic [1:0] move
);

    localparam int unsigned   CW        = (DB_TICKS < 2) ? 1 : $clog2(DB_TICKS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DB_TICKS - 1);
    localparam int unsigned   RMAX      = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned   RW        = $clog2(RMAX + 1);
    localparam logic [RW-1:0] R_DELAY   = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] R_PERIOD  = RW'(REPEAT_PERIOD);
    localparam logic          REPEAT_EN = (REPEAT_DELAY != 0);

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    logic [1:0]    sync1;
    logic [1:0]    sync2;
    state_t        state     [2];
    state_t        state_nxt [2];
    logic [CW-1:0] cnt       [2];
    logic [CW-1:0] cnt_nxt   [2];
    logic [RW-1:0] rcnt      [2];
    logic [RW-1:0] rcnt_nxt  [2];
    logic [1:0]    armed;
    logic [1:0]    armed_nxt;
    logic [1:0]    rep;
    logic [1:0]    rep_nxt;
    logic [1:0]    db_nxt;
    logic [1:0]    tick_nxt;
    logic [1:0]    held;
    logic [1:0]    enter_one;

    // Two-flop synchronizer per raw button bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Debounce next-state, output decode and auto-repeat bookkeeping per channel.
    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            case (state[i])
                ZERO: begin
                    if (sync2[i]) begin
                        state_nxt[i] = WAIT1;
                        cnt_nxt[i]   = '0;
                    end
                end
                WAIT1: begin
                    if (!sync2[i])
                        state_nxt[i] = ZERO;
                    else if (cnt[i] == CNT_LAST)
                        state_nxt[i] = ONE;
                    else
                        cnt_nxt[i] = cnt[i] + 1'b1;
                end
                ONE: begin
                    if (!sync2[i]) begin
                        state_nxt[i] = WAIT0;
                        cnt_nxt[i]   = '0;
                    end
                end
                WAIT0: begin
                    if (sync2[i])
                        state_nxt[i] = ONE;
                    else if (cnt[i] == CNT_LAST)
                        state_nxt[i] = ZERO;
                    else
                        cnt_nxt[i] = cnt[i] + 1'b1;
                end
                default: state_nxt[i] = ZERO;
            endcase

            db_nxt[i]    = (state_nxt[i] == ONE) || (state_nxt[i] == WAIT0);
            tick_nxt[i]  = (state[i] == WAIT1) && (state_nxt[i] == ONE);
            held[i]      = ((state[i] == ONE) || (state[i] == WAIT0)) && db_nxt[i];
            enter_one[i] = (state_nxt[i] == ONE) && (state[i] != ONE);

            // One counter serves both intervals: it restarts after every pulse
            // and 'armed' switches its target from the delay to the period.
            rcnt_nxt[i]  = '0;
            armed_nxt[i] = 1'b0;
            rep_nxt[i]   = 1'b0;
            if (held[i] && !enter_one[i]) begin
                armed_nxt[i] = armed[i];
                rcnt_nxt[i]  = (rcnt[i] != '1) ? rcnt[i] + 1'b1 : rcnt[i];
                if (REPEAT_EN && (rcnt_nxt[i] == (armed[i] ? R_PERIOD : R_DELAY))) begin
                    rep_nxt[i]   = 1'b1;
                    rcnt_nxt[i]  = '0;
                    armed_nxt[i] = 1'b1;
                end
            end
        end
    end

    // State, counters and registered outputs; move blocks a channel while the other is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 2; i++) begin
                state[i] <= ZERO;
                cnt[i]   <= '0;
                rcnt[i]  <= '0;
            end
            armed    <= '0;
            rep      <= '0;
            btn_db   <= '0;
            btn_tick <= '0;
            move     <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
                rcnt[i]  <= rcnt_nxt[i];
            end
            armed    <= armed_nxt;
            rep      <= rep_nxt;
            btn_db   <= db_nxt;
            btn_tick <= tick_nxt;
            move     <= (btn_tick | rep) & ~{btn_db[0], btn_db[1]};
        end
    end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 Parameter DB_TICKS, default 1000000, stable cycles required to accept a level change (10 ms at 100 MHz); legal range 2..2^24-1.
REQ-002 Parameter REPEAT_DELAY, default 30000000, cycles held in ONE before the first auto-repeat pulse; 0 disables auto-repeat.
REQ-003 Parameter REPEAT_PERIOD, default 10000000, cycles between subsequent auto-repeat pulses; legal range 1..2^26-1.
REQ-004 clk  input  1  system clock, rising edge; the 100 MHz clock that drives the game core.
REQ-005 reset  input  1  one clock; reset is asynchronous and active-low.
REQ-006 btn_raw  input  2  raw, asynchronous push-button levels; bit 0 = paddle up, bit 1 = paddle down.
REQ-007 btn_db  output  2  debounced button levels.
REQ-008 btn_tick  output  2  one-cycle pulse on each accepted press (rising debounced edge).
REQ-009 move  output  2  one-cycle paddle-move pulses to the game core; press pulse plus auto-repeat.

Function
REQ-010 Each bit of btn_raw SHALL pass through a private 2-flop synchronizer; downstream logic SHALL use only the second flop output s[i].
REQ-011 Each channel SHALL run an independent FSM with states ZERO, WAIT1, ONE, WAIT0 and its own debounce counter of ceil(log2(DB_TICKS)) bits.
REQ-012 ZERO: s=1 -> WAIT1, counter cleared; s=0 -> stay.
REQ-013 WAIT1: s=0 -> ZERO; s=1 and counter==DB_TICKS-1 -> ONE; otherwise counter+1.
REQ-014 ONE: s=0 -> WAIT0, counter cleared; s=1 -> stay.
REQ-015 WAIT0: s=1 -> ONE; s=0 and counter==DB_TICKS-1 -> ZERO; otherwise counter+1.
REQ-016 btn_db[i] SHALL be registered, high exactly when channel i is in ONE or WAIT0.
REQ-017 btn_tick[i] SHALL be registered and high for exactly one cycle, coincident with the WAIT1->ONE transition; WAIT0->ONE SHALL NOT generate a tick.
REQ-018 Latency: raw rising before edge 1 and held stable -> ONE, btn_db and btn_tick valid after rising edge DB_TICKS+3; release mirrors this with btn_db falling after edge DB_TICKS+3.
REQ-019 Glitches shorter than DB_TICKS synchronized cycles SHALL produce no change on any output.
REQ-020 Repeat counter per channel: cleared on entry to ONE; counts only while in ONE or WAIT0; repeat pulse when count reaches REPEAT_DELAY, then every REPEAT_PERIOD cycles thereafter; saturates rather than wraps between pulses.
REQ-021 move[i] SHALL be registered = (btn_tick[i] OR repeat pulse[i]) AND NOT btn_db[1-i] (next-cycle values), i.e. pulses one cycle after the corresponding btn_tick.
REQ-022 Both channels debounced high simultaneously: move SHALL be 2'b00 for as long as both are high; btn_db and btn_tick unaffected.
REQ-023 Both channels accepting a press on the same cycle: both btn_tick bits pulse, move stays 2'b00.
REQ-024 move SHALL never have both bits high in any cycle.

Reset
REQ-025 reset low SHALL immediately (asynchronously) force synchronizers to 0, FSMs to ZERO, all counters to 0, and btn_db, btn_tick, move to 2'b00.
REQ-026 Reset asserted mid-debounce or mid-repeat SHALL discard progress; after release a held button SHALL require a full DB_TICKS+3 edges again and SHALL produce a fresh btn_tick.
REQ-027 Release of reset SHALL be synchronous to clk by an external synchronizer; the block generates no output pulses on reset release alone.

Verification (DB_TICKS=4, REPEAT_DELAY=8, REPEAT_PERIOD=3)
REQ-028 btn_raw=01 held from cycle 0 -> btn_db=01 and btn_tick=01 at edge 7; move=01 at edge 8; btn_tick single cycle.
REQ-029 btn_raw[0] pulses high for 3 cycles then low -> btn_db, btn_tick, and move remain 00 throughout.
REQ-030 btn_raw=10 held 30 cycles -> move[1] pulses at edges 8, 16, 19, 22, 25, ...; released -> btn_db[1] falls 7 edges after release, no further move pulses.
REQ-031 btn_raw=11 applied together -> btn_tick=11 at edge 7, move stays 00 throughout; release bit 1 only -> move[0] repeat pulses resume once btn_db[1]=0.
REQ-032 reset driven low at edge 5 with btn_raw=01 held, released at edge 10 -> outputs 00 immediately, btn_tick[0] pulses at edge 17.
